// File: rtl/lsu_mem_queue_pkg.sv
// Shared types for the LSU memory queue: op sizes, queue entry layout, mainMem request/response.
// Latency: n/a (types and pure combinational helpers only).
// Backpressure: n/a.
package lsu_mem_queue_pkg;

    // Tag width carried inside a queue entry; the top-level TAG_W must not exceed this.
    localparam int LSQ_TAG_W = 6;

    // mainMem is 32 bytes; only the low address bits are decoded and it wraps modulo its size.
    localparam int MEM_ADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } memSize_e;

    typedef enum logic {
        ISSUE  = 1'b0,
        RMW_WR = 1'b1
    } lsqState_e;

    typedef struct packed {
        logic                 is_store;
        memSize_e             size;
        logic                 is_unsigned;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [LSQ_TAG_W-1:0] tag;
    } lsqEntryStruct;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic        MemWrite;
        logic        MemRead;
        logic        valid;
    } memReqStruct;

    typedef struct packed {
        logic [31:0] rd_data;
    } memRespStruct;

    // Store merge for read-modify-write: keep the memory word, overlay the low store bytes.
    function automatic logic [31:0] merge_store(input logic [31:0] rd, input logic [31:0] wd,
                                                input memSize_e size);
        case (size)
            MEM_B:   return {rd[31:8], wd[7:0]};
            MEM_H:   return {rd[31:16], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    // Load extension: sub-word results come from the low bytes of the read word.
    function automatic logic [31:0] extend_load(input logic [31:0] rd, input memSize_e size,
                                                input logic is_unsigned);
        case (size)
            MEM_B:   return {{24{~is_unsigned & rd[7]}}, rd[7:0]};
            MEM_H:   return {{16{~is_unsigned & rd[15]}}, rd[15:0]};
            default: return rd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_queue_fifo.sv
// In-order entry buffer for the LSU queue: DEPTH x lsqEntryStruct, circular pointers plus occupancy count.
// Latency: a pushed entry is visible at head the cycle after the push edge (no fall-through).
// Backpressure: push is ignored when full, pop ignored when empty; caller gates with full/empty.
//
// Ports: clk, reset (async, active-high), push/push_data, pop, head (current oldest entry),
//        count (registered occupancy), full, empty.
module lsu_fifo
    import lsu_mem_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  lsqEntryStruct              push_data,
    input  logic                       pop,
    output lsqEntryStruct              head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    lsqEntryStruct          store_q [0:DEPTH-1];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   push_ok;
    logic                   pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = store_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: only slots between rd_ptr and wr_ptr are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lsu_mem_queue.sv
// In-order load/store queue in front of single-port mainMem: one request per cycle, RMW for sub-word stores.
// Latency: enqueue edge -> request next cycle -> load result registered on the following edge; sub-word store 2 cycles.
// Backpressure: in_ready from registered occupancy only; a head load waits (no request) while the wb register is held.
//
// Ports: clk, reset (async, active-high); in_* op offer with in_valid/in_ready; mem_req/mem_resp to mainMem
//        (rd_data combinational with the request); wb_valid/wb_ready/wb_tag/wb_data load results.
module lsu_mem_queue
    import lsu_mem_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    output memReqStruct       mem_req,
    input  memRespStruct      mem_resp,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [31:0]       wb_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    lsqEntryStruct      in_entry;
    lsqEntryStruct      head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               pop;
    logic               load_fire;
    logic               rmw_rd;
    logic               wb_free;
    lsqState_e          state;
    logic [31:0]        merge_q;

    // Registered count only, so a full queue refuses even when the head pops this cycle.
    assign in_ready  = (fifo_count < CNT_W'(DEPTH));
    assign fifo_push = in_valid && !fifo_full;
    assign wb_free   = !wb_valid || wb_ready;

    // Size 2'b11 is folded to word on entry so downstream logic sees only legal sizes.
    always_comb begin
        in_entry             = '0;
        in_entry.is_store    = in_is_store;
        in_entry.size        = (in_size == 2'b11) ? MEM_W : memSize_e'(in_size);
        in_entry.is_unsigned = in_unsigned;
        in_entry.addr        = in_addr;
        in_entry.wdata       = in_wdata;
        in_entry.tag         = LSQ_TAG_W'(in_tag);
    end

    lsu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Request decode from head entry and state. Any cycle without a request drives all-zero,
    // which also makes reset drop the request as soon as the queue and state flops clear.
    always_comb begin
        mem_req   = '0;
        pop       = 1'b0;
        load_fire = 1'b0;
        rmw_rd    = 1'b0;
        if (!fifo_empty) begin
            case (state)
                ISSUE: begin
                    if (!head.is_store) begin
                        if (wb_free) begin
                            mem_req.valid   = 1'b1;
                            mem_req.MemRead = 1'b1;
                            mem_req.addr    = head.addr;
                            pop             = 1'b1;
                            load_fire       = 1'b1;
                        end
                    end else if (head.size == MEM_W) begin
                        mem_req.valid    = 1'b1;
                        mem_req.MemWrite = 1'b1;
                        mem_req.addr     = head.addr;
                        mem_req.wr_data  = head.wdata;
                        pop              = 1'b1;
                    end else begin
                        // Sub-word store, first half: fetch the word to merge into.
                        mem_req.valid   = 1'b1;
                        mem_req.MemRead = 1'b1;
                        mem_req.addr    = head.addr;
                        rmw_rd          = 1'b1;
                    end
                end
                RMW_WR: begin
                    mem_req.valid    = 1'b1;
                    mem_req.MemWrite = 1'b1;
                    mem_req.addr     = head.addr;
                    mem_req.wr_data  = merge_q;
                    pop              = 1'b1;
                end
                default: begin
                    mem_req = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ISSUE;
            merge_q  <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_tag   <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    if (rmw_rd) begin
                        merge_q <= merge_store(mem_resp.rd_data, head.wdata, head.size);
                        state   <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    state <= ISSUE;
                end
                default: begin
                    state <= ISSUE;
                end
            endcase

            // A new load result takes priority over clearing on handshake (back-to-back loads).
            if (load_fire) begin
                wb_valid <= 1'b1;
                wb_data  <= extend_load(mem_resp.rd_data, head.size, head.is_unsigned);
                wb_tag   <= TAG_W'(head.tag);
            end else if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
                wb_data  <= '0;
                wb_tag   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_queue.sv
// Bench for lsu_mem_queue: byte-array mainMem, program-order reference memory, expected-result queue.
module tb_lsu_mem_queue;
    import lsu_mem_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_store;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic [31:0]       in_addr;
    logic [31:0]       in_wdata;
    logic [TAG_W-1:0]  in_tag;
    memReqStruct       mem_req;
    memRespStruct      mem_resp;
    logic              wb_valid;
    logic              wb_ready;
    logic [TAG_W-1:0]  wb_tag;
    logic [31:0]       wb_data;

    always #5 clk = ~clk;

    lsu_mem_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_is_store (in_is_store),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_tag      (in_tag),
        .mem_req     (mem_req),
        .mem_resp    (mem_resp),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data)
    );

    // ---------------- mainMem: 32 bytes, little-endian, wraps mod 32 ----------------
    logic [7:0] mem     [0:31];
    logic [7:0] ref_mem [0:31];
    logic [7:0] saved   [0:31];
    wire  [4:0] ma = mem_req.addr[4:0];

    assign mem_resp.rd_data = {mem[5'(ma + 5'd3)], mem[5'(ma + 5'd2)], mem[5'(ma + 5'd1)], mem[ma]};

    always @(posedge clk) begin
        if (mem_req.valid && mem_req.MemWrite) begin
            for (int k = 0; k < 4; k++) mem[5'(ma + 5'(k))] <= mem_req.wr_data[8*k +: 8];
        end
    end

    // ---------------- scoring ----------------
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: every op takes effect on ref_mem in program order at enqueue time.
    task automatic ref_apply(input logic st, input logic [1:0] sz, input logic un,
                             input logic [31:0] ad, input logic [31:0] wd, input logic [TAG_W-1:0] tg);
        int nb;
        logic [31:0] v;
        exp_t e;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (st) begin
            for (int k = 0; k < nb; k++) ref_mem[5'(ad[4:0] + 5'(k))] = wd[8*k +: 8];
        end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[5'(ad[4:0] + 5'(k))]) << (8*k));
            if (!un && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
            e.tag  = tg;
            e.data = v;
            exp_q.push_back(e);
        end
    endtask

    // Offer one op; waits (bounded) for in_ready, then holds it over one edge.
    task automatic push(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [TAG_W-1:0] tg);
        int n;
        n = 0;
        in_is_store = st; in_size = sz; in_unsigned = un;
        in_addr = ad; in_wdata = wd; in_tag = tg; in_valid = 1'b1;
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        if (!in_ready) begin
            fail_now("push_ready");
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            ref_apply(st, sz, un, ad, wd, tg);
        end
    endtask

    task automatic expect_wb(input string nm, input logic [TAG_W-1:0] tg, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(wb_valid && wb_ready) && n < 100) begin @(negedge clk); n++; end
        if (!(wb_valid && wb_ready)) fail_now({nm, "_wait"});
        else begin
            check({nm, "_data"}, wb_data, d);
            check({nm, "_tag"}, 32'(wb_tag), 32'(tg));
        end
    endtask

    task automatic check_mem_image(input string nm);
        int nbad;
        nbad = 0;
        for (int k = 0; k < 32; k++) if (mem[k] !== ref_mem[k]) nbad++;
        check(nm, 32'(nbad), 32'd0);
    endtask

    // Per-cycle compare against the reference queue and the protocol rules.
    logic             stall_prev = 1'b0;
    logic [TAG_W-1:0] tag_prev;
    logic [31:0]      data_prev;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            check("rd_wr_excl", 32'(mem_req.MemRead && mem_req.MemWrite), 32'd0);
            if (!mem_req.valid) check("idle_req_zero", 32'(mem_req != '0), 32'd0);
            if (stall_prev) begin
                check("hold_valid", 32'(wb_valid), 32'd1);
                check("hold_tag", 32'(wb_tag), 32'(tag_prev));
                check("hold_data", wb_data, data_prev);
            end
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 32'(wb_valid), 32'd0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("model_tag", 32'(wb_tag), 32'(e_cur.tag));
                    check("model_data", wb_data, e_cur.data);
                end
            end
            stall_prev = wb_valid && !wb_ready;
            tag_prev   = wb_tag;
            data_prev  = wb_data;
        end
    end

    // wb_ready has a single driver, updated just after the rising edge.
    logic rand_wb  = 1'b0;
    logic wb_force = 1'b1;
    initial begin
        wb_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            wb_ready = rand_wb ? ($urandom_range(3) != 0) : wb_force;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        int n;
        for (int k = 0; k < 32; k++) begin mem[k] = 8'h00; ref_mem[k] = 8'h00; end
        reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
        in_addr = '0; in_wdata = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_tag", 32'(wb_tag), 32'd0);
        check("rst_mem_req", 32'(mem_req != '0), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // 1: word store then word load at the same address
        push(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF, 6'd0);
        @(negedge clk);
        check("sw_write", {29'd0, mem_req.MemWrite, mem_req.MemRead, mem_req.valid}, 32'b101);
        check("sw_addr", mem_req.addr, 32'd4);
        check("sw_wdata", mem_req.wr_data, 32'hDEADBEEF);
        push(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 6'd3);
        @(negedge clk);
        check("lw_read", {29'd0, mem_req.MemWrite, mem_req.MemRead, mem_req.valid}, 32'b011);
        check("lw_addr", mem_req.addr, 32'd4);
        expect_wb("lw4", 6'd3, 32'hDEADBEEF);

        // 2: byte store uses read then write; upper wdata bits must be ignored
        push(1'b1, 2'd0, 1'b0, 32'd5, 32'hAAAAAA7F, 6'd0);
        @(negedge clk);
        check("sb_rmw_rd", {29'd0, mem_req.MemWrite, mem_req.MemRead, mem_req.valid}, 32'b011);
        check("sb_rmw_rd_addr", mem_req.addr, 32'd5);
        @(negedge clk);
        check("sb_rmw_wr", {29'd0, mem_req.MemWrite, mem_req.MemRead, mem_req.valid}, 32'b101);
        check("sb_rmw_wr_addr", mem_req.addr, 32'd5);
        check("sb_rmw_wdata", mem_req.wr_data, 32'h00DEAD7F);
        push(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 6'd4);
        expect_wb("lw4_merged", 6'd4, 32'hDEAD7FEF);

        // 3: sign/zero extension
        push(1'b1, 2'd0, 1'b0, 32'd6, 32'h55555580, 6'd0);
        push(1'b0, 2'd0, 1'b0, 32'd6, 32'd0, 6'd5);
        expect_wb("lb6", 6'd5, 32'hFFFFFF80);
        push(1'b0, 2'd0, 1'b1, 32'd6, 32'd0, 6'd6);
        expect_wb("lbu6", 6'd6, 32'h00000080);
        push(1'b0, 2'd1, 1'b0, 32'd5, 32'd0, 6'd7);
        expect_wb("lh5", 6'd7, 32'hFFFF807F);

        // 4: word store wrapping 31->0: bytes 30..1 = 44,33,22,11, so half at 0 = 0x1122
        push(1'b1, 2'd2, 1'b0, 32'd30, 32'h11223344, 6'd0);
        push(1'b0, 2'd1, 1'b1, 32'h00000100, 32'd0, 6'd8);
        expect_wb("lhu0_wrap", 6'd8, 32'h00001122);

        // 5: writeback stalled -> DEPTH queued plus one held in the wb register
        wb_force = 1'b0;
        @(posedge clk); #2;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (!in_ready) break;
            push(1'b0, 2'($urandom_range(3)), 1'($urandom_range(1)), $urandom, 32'd0, 6'(10 + i));
            acc++;
        end
        check("stall_accepted", 32'(acc), 32'(DEPTH + 1));
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_no_req", 32'(mem_req.valid), 32'd0);
        repeat (4) @(negedge clk);
        wb_force = 1'b1;
        n = 0;
        while (!(wb_valid && wb_ready) && n < 20) begin @(negedge clk); n++; end
        if (!(wb_valid && wb_ready)) fail_now("drain_start");
        for (int i = 1; i < DEPTH + 1; i++) begin
            @(negedge clk);
            check("drain_back_to_back", 32'(wb_valid && wb_ready), 32'd1);
        end
        @(negedge clk);
        check("drain_done", 32'(wb_valid), 32'd0);

        // Randomised traffic with random writeback stalls
        rand_wb = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
            push(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                 ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(31)),
                 $urandom, 6'($urandom_range(63)));
        end
        rand_wb = 1'b0;
        wb_force = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) fail_now("random_drain");
        repeat (2 * DEPTH + 4) @(negedge clk);
        check_mem_image("mem_image_random");

        // 6: reset lands in the write half of a byte store
        for (int k = 0; k < 32; k++) saved[k] = ref_mem[k];
        push(1'b1, 2'd0, 1'b0, 32'd10, 32'h000000A5, 6'd0);
        @(posedge clk); #1;
        check("rmw_wr_cycle", {29'd0, mem_req.MemWrite, mem_req.MemRead, mem_req.valid}, 32'b101);
        reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req.valid), 32'd0);
        check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 32; k++) ref_mem[k] = saved[k];
        exp_q.delete();
        check_mem_image("mem_image_after_reset");

        // Queue still works after the mid-operation reset
        push(1'b0, 2'd2, 1'b0, 32'd10, 32'd0, 6'd9);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) fail_now("post_reset_load");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
